// File: rtl/energy_phase_sel_pkg.sv
// -----------------------------------------------------------------------------
// energy_phase_sel_pkg
// Shared definitions for the automatic symbol-timing stage:
//   - phase_sel_state_e : decision FSM encoding (SYNC, ACCUM, DECIDE, COMMIT)
//   - DEF_NB / DEF_OS   : default sample width and oversampling factor, shared
//                         with the RC filter and the receiver control logic
//   - DEF_NB_WIN        : default log2 of the decision window in symbols
//   - clog2()           : constant-friendly ceiling log2
//   - sat_abs()         : |x| saturated to the largest positive nb-bit value
// -----------------------------------------------------------------------------
package energy_phase_sel_pkg;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACCUM  = 2'd1,
        DECIDE = 2'd2,
        COMMIT = 2'd3
    } phase_sel_state_e;

    localparam int DEF_NB     = 8;
    localparam int DEF_OS     = 4;
    localparam int DEF_NB_WIN = 10;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

    // The most negative code has no positive twin, so it folds onto the
    // largest positive code instead of wrapping back to itself.
    function automatic logic [31:0] sat_abs(input logic signed [31:0] x,
                                            input int                 nb);
        logic signed [31:0] max_v;
        logic signed [31:0] a;
        max_v = (32'sd1 <<< (nb - 1)) - 32'sd1;
        a     = (x < 0) ? -x : x;
        if (a > max_v) begin
            a = max_v;
        end
        return a;
    endfunction

endpackage

// File: rtl/energy_phase_sel_phase_accum_bank.sv
// -----------------------------------------------------------------------------
// energy_phase_sel_phase_accum_bank
// Bank of OS unsigned energy accumulators, one per oversampling phase.
//   clock, reset : system clock, asynchronous active-high reset
//   i_clear      : zero every accumulator (wins over i_add_en)
//   i_add_en     : add i_add_mag into the accumulator selected by i_add_idx
//   i_add_idx    : accumulator index for the add
//   i_add_mag    : saturated magnitude, NB-1 bits
//   i_rd_idx     : accumulator index for the combinational read
//   o_rd_data    : contents of accumulator i_rd_idx
// Width NB-1+NB_WIN holds 2^NB_WIN maximal magnitudes, so no add can overflow.
// -----------------------------------------------------------------------------
module energy_phase_sel_phase_accum_bank
    import energy_phase_sel_pkg::*;
#(
    parameter  int NB     = DEF_NB,
    parameter  int OS     = DEF_OS,
    parameter  int NB_WIN = DEF_NB_WIN,
    localparam int PH_W   = clog2(OS),
    localparam int NB_ACC = NB - 1 + NB_WIN
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_clear,
    input  logic              i_add_en,
    input  logic [PH_W-1:0]   i_add_idx,
    input  logic [NB-2:0]     i_add_mag,
    input  logic [PH_W-1:0]   i_rd_idx,
    output logic [NB_ACC-1:0] o_rd_data
);

    logic [NB_ACC-1:0] acc_q [OS];
    logic [NB_ACC-1:0] acc_d [OS];

    always_comb begin
        for (int k = 0; k < OS; k++) begin
            acc_d[k] = acc_q[k];
            if (i_clear) begin
                acc_d[k] = '0;
            end else if (i_add_en && (i_add_idx == PH_W'(k))) begin
                acc_d[k] = acc_q[k] + NB_ACC'(i_add_mag);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < OS; k++) begin
                acc_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < OS; k++) begin
                acc_q[k] <= acc_d[k];
            end
        end
    end

    assign o_rd_data = acc_q[i_rd_idx];

endmodule

// File: rtl/energy_phase_sel.sv
// -----------------------------------------------------------------------------
// energy_phase_sel
// Automatic symbol-timing stage between the RC filter and the BER/sync checker.
// Accumulates |sample| per oversampling phase over 2^NB_WIN symbols, picks the
// phase with the most energy and slices the sign of that phase's sample into
// one rx bit per symbol. Windows repeat back to back, so a drifting eye is
// tracked.
//   clock        : system clock
//   reset        : asynchronous active-high reset
//   i_enable     : block enable; low forces SYNC, clears the window, unlocks
//   i_valid      : symbol strobe, one clock in every OS, marks phase 0
//   i_sample     : signed filter output, one sample per clock
//   o_phase      : currently selected phase
//   o_locked     : a window decision has been committed since enable
//   o_bit        : sign of the selected-phase sample (1 = negative)
//   o_bit_valid  : one-clock pulse per symbol qualifying o_bit
// Optional build macro PHASE_HYST_EN: once locked, a new best phase only
// replaces o_phase if its energy beats the current phase's by more than 1/8.
// -----------------------------------------------------------------------------
module energy_phase_sel
    import energy_phase_sel_pkg::*;
#(
    parameter  int NB     = DEF_NB,
    parameter  int OS     = DEF_OS,
    parameter  int NB_WIN = DEF_NB_WIN,
    localparam int PH_W   = clog2(OS)
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_enable,
    input  logic                 i_valid,
    input  logic signed [NB-1:0] i_sample,
    output logic [PH_W-1:0]      o_phase,
    output logic                 o_locked,
    output logic                 o_bit,
    output logic                 o_bit_valid
);

    localparam int                NB_ACC   = NB - 1 + NB_WIN;
    localparam int                MAG_W    = NB - 1;
    localparam logic [NB_WIN-1:0] WIN_LAST = '1;
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(OS - 1);

    phase_sel_state_e  state_q,    state_d;
    logic [PH_W-1:0]   ph_cnt_q,   ph_cnt_d;
    logic [NB_WIN-1:0] win_cnt_q,  win_cnt_d;
    logic [PH_W-1:0]   dec_idx_q,  dec_idx_d;
    logic [NB_ACC-1:0] best_val_q, best_val_d;
    logic [PH_W-1:0]   best_idx_q, best_idx_d;
    logic [PH_W-1:0]   o_phase_q,  o_phase_d;
    logic              locked_q,   locked_d;
    logic              bit_q,      bit_d;
    logic              bit_vld_q,  bit_vld_d;

    logic [PH_W-1:0]   cur_phase;
    logic [MAG_W-1:0]  mag;
    logic              acc_clear;
    logic              acc_add_en;
    logic [PH_W-1:0]   acc_rd_idx;
    logic [NB_ACC-1:0] acc_rd;

    // The strobe itself defines phase 0, so a slipped strobe re-aligns the
    // phase count on the very cycle it arrives.
    assign cur_phase = i_valid ? '0 : ph_cnt_q;
    assign ph_cnt_d  = i_valid ? PH_W'(1) : (ph_cnt_q + PH_W'(1));

    assign mag = MAG_W'(sat_abs({{(32 - NB){i_sample[NB-1]}}, i_sample}, NB));

    energy_phase_sel_phase_accum_bank #(
        .NB     (NB),
        .OS     (OS),
        .NB_WIN (NB_WIN)
    ) u_bank (
        .clock     (clock),
        .reset     (reset),
        .i_clear   (acc_clear),
        .i_add_en  (acc_add_en),
        .i_add_idx (cur_phase),
        .i_add_mag (mag),
        .i_rd_idx  (acc_rd_idx),
        .o_rd_data (acc_rd)
    );

`ifdef PHASE_HYST_EN
    logic [NB_ACC:0] hyst_thresh;
    assign hyst_thresh = {1'b0, acc_rd} + {4'b0000, acc_rd[NB_ACC-1:3]};
`endif

    // Window FSM: accumulate, scan the bank one entry per clock, commit.
    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        dec_idx_d  = dec_idx_q;
        best_val_d = best_val_q;
        best_idx_d = best_idx_q;
        o_phase_d  = o_phase_q;
        locked_d   = locked_q;
        acc_clear  = 1'b0;
        acc_add_en = 1'b0;
        acc_rd_idx = dec_idx_q;

        if (!i_enable) begin
            state_d    = SYNC;
            win_cnt_d  = '0;
            dec_idx_d  = '0;
            best_val_d = '0;
            best_idx_d = '0;
            locked_d   = 1'b0;
            acc_clear  = 1'b1;
        end else begin
            case (state_q)
                SYNC: begin
                    if (i_valid) begin
                        state_d    = ACCUM;
                        win_cnt_d  = '0;
                        acc_add_en = 1'b1;
                    end
                end
                ACCUM: begin
                    // The strobe that would complete the count opens the next
                    // symbol, which belongs to no window.
                    if (i_valid && (win_cnt_q == WIN_LAST)) begin
                        state_d    = DECIDE;
                        dec_idx_d  = '0;
                        best_val_d = '0;
                        best_idx_d = '0;
                    end else begin
                        acc_add_en = 1'b1;
                        if (i_valid) begin
                            win_cnt_d = win_cnt_q + NB_WIN'(1);
                        end
                    end
                end
                DECIDE: begin
                    // Strictly greater, so equal energies keep the lower index.
                    if (acc_rd > best_val_q) begin
                        best_val_d = acc_rd;
                        best_idx_d = dec_idx_q;
                    end
                    dec_idx_d = dec_idx_q + PH_W'(1);
                    if (dec_idx_q == PH_LAST) begin
                        state_d = COMMIT;
                    end
                end
                COMMIT: begin
                    acc_rd_idx = o_phase_q;
`ifdef PHASE_HYST_EN
                    if (!locked_q || ({1'b0, best_val_q} > hyst_thresh)) begin
                        o_phase_d = best_idx_q;
                    end
`else
                    o_phase_d = best_idx_q;
`endif
                    locked_d  = 1'b1;
                    win_cnt_d = '0;
                    acc_clear = 1'b1;
                    state_d   = SYNC;
                end
                default: begin
                    state_d = SYNC;
                end
            endcase
        end
    end

    // Slicer: runs regardless of the FSM state.
    always_comb begin
        bit_d     = bit_q;
        bit_vld_d = 1'b0;
        if (i_enable && (cur_phase == o_phase_q)) begin
            bit_d     = i_sample[NB-1];
            bit_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= SYNC;
            ph_cnt_q   <= '0;
            win_cnt_q  <= '0;
            dec_idx_q  <= '0;
            best_val_q <= '0;
            best_idx_q <= '0;
            o_phase_q  <= '0;
            locked_q   <= 1'b0;
            bit_q      <= 1'b0;
            bit_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ph_cnt_q   <= ph_cnt_d;
            win_cnt_q  <= win_cnt_d;
            dec_idx_q  <= dec_idx_d;
            best_val_q <= best_val_d;
            best_idx_q <= best_idx_d;
            o_phase_q  <= o_phase_d;
            locked_q   <= locked_d;
            bit_q      <= bit_d;
            bit_vld_q  <= bit_vld_d;
        end
    end

    assign o_phase     = o_phase_q;
    assign o_locked    = locked_q;
    assign o_bit       = bit_q;
    assign o_bit_valid = bit_vld_q;

endmodule
